// File: rtl/mem_pkg.sv
// Shared defaults and helpers for the banked data memory.
package mem_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned NB_LOG2_DEF    = 3;
  localparam int unsigned BANK_AW_DEF    = 10;
  localparam int unsigned RSP_FIFO_DEPTH = 3;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One synchronous single-port bank: byte-enable write, registered read.
module mem_bank
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AW     = BANK_AW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Storage array: byte-masked write, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be[i]) begin
          mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read register only loads on a read, so it holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[addr];
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_mem_pipe.sv
// Pipelined banked data memory with request handshake and a small response FIFO.
module banked_mem_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NB_LOG2 = NB_LOG2_DEF,
  parameter int unsigned BANK_AW = BANK_AW_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [NB_LOG2+BANK_AW-1:0]  req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [DATA_W/8-1:0]         req_be,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data
);

  localparam int unsigned ADDR_W = NB_LOG2 + BANK_AW;
  localparam int unsigned NBANKS = 2 ** NB_LOG2;
  localparam int unsigned PTR_W  = clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CNT_W  = clog2(RSP_FIFO_DEPTH + 1);

  logic                fire;
  logic [NB_LOG2-1:0]  bank_sel;
  logic [BANK_AW-1:0]  bank_word;
  logic [NBANKS-1:0]   bank_en;
  logic [DATA_W-1:0]   bank_rdata [NBANKS];

  logic                s1_valid_d, s1_valid_q;
  logic [NB_LOG2-1:0]  s1_bank_d, s1_bank_q;

  logic [DATA_W-1:0]   fifo_d [RSP_FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_q [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                push, pop;
  logic [DATA_W-1:0]   push_data;
  logic [CNT_W:0]      occupancy;

  assign fire      = req_valid && req_ready;
  assign bank_sel  = req_addr[ADDR_W-1:BANK_AW];
  assign bank_word = req_addr[BANK_AW-1:0];

  // One-hot bank enable; idle banks see no activity.
  always_comb begin
    bank_en = '0;
    for (int i = 0; i < NBANKS; i++) begin
      bank_en[i] = fire && (bank_sel == NB_LOG2'(i));
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_W (DATA_W),
      .AW     (BANK_AW)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bank_en[g]),
      .we    (req_we),
      .addr  (bank_word),
      .wdata (req_wdata),
      .be    (req_be),
      .rdata (bank_rdata[g])
    );
  end

  // Stage 1 tracks which bank holds the in-flight read word.
  always_comb begin
    s1_valid_d = fire && !req_we;
    s1_bank_d  = s1_valid_d ? bank_sel : s1_bank_q;
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bank_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bank_q  <= s1_bank_d;
    end
  end

  assign push      = s1_valid_q;
  assign push_data = bank_rdata[s1_bank_q];
  assign pop       = rsp_valid && rsp_ready;

  // Response FIFO next state: mod-3 pointers, simultaneous push/pop allowed.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = push_data;
      wptr_d = (wptr_q == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Ready counts the in-flight read as occupied so the FIFO can never overflow;
  // it depends on registered state only.
  always_comb begin
    occupancy = (CNT_W + 1)'(s1_valid_q) + (CNT_W + 1)'(cnt_q);
    req_ready = occupancy < (CNT_W + 1)'(RSP_FIFO_DEPTH);
    rsp_valid = (cnt_q != '0);
    rsp_data  = rsp_valid ? fifo_q[rptr_q] : '0;
  end

endmodule
